mem_phase_scheduler: RTL

Sequencer that lets the processor share one single-ported unified instruction/data memory. It splits each instruction into a fetch phase and an optional data phase, and runs a variable-latency request/ready handshake with the memory. It gates architectural updates (PC, register file) to one commit pulse per instruction and parks the core after a halting instruction. It sits between the control unit outputs (MemRead, MemWrite, halt decode), the PC/IR registers and the memory.

---
 rtl/mem_phase_scheduler.sv | 106 ++++++++++
 1 files changed

// File: rtl/mem_phase_scheduler.sv
// Fetch/execute/data phase sequencer for a core sharing one single-ported
// instruction/data memory; gates PC and register-file updates to one commit per instruction.
module mem_phase_scheduler #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              halt_req,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_sel_data,
    output logic              ir_load,
    output logic              commit,
    output logic              halted,
    output logic [CNT_W-1:0]  instr_count
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_DATA  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Outputs are forced low while rst is high so an in-flight access is dropped
    // and never produces ir_load or commit.
    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_sel_data = 1'b0;
        ir_load      = 1'b0;
        commit       = 1'b0;
        halted       = 1'b0;
        if (!rst) begin
            unique case (state_q)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    mem_addr = pc;
                    if (mem_ready) begin
                        ir_load = 1'b1;
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (halt_req) begin
                        state_d = S_HALT;
                    end else if (mem_read || mem_write) begin
                        state_d = S_DATA;
                    end else begin
                        commit  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_DATA: begin
                    // A write takes precedence when both read and write are decoded.
                    mem_req      = 1'b1;
                    mem_we       = mem_write;
                    mem_addr     = data_addr;
                    mem_sel_data = 1'b1;
                    if (mem_ready) begin
                        commit  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        if (commit) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign instr_count = count_q;

endmodule
